// File: rtl/byte_word_assembler_ctrl.sv
// Byte-to-word sequencer for an external byte-wide left-shift register.
// Counts accepted bytes, holds the finished word, drops stale partials.
module byte_word_assembler_ctrl #(
    parameter int N       = 32,
    parameter int TIMEOUT = 1000,
    parameter int CW      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      sr_h,
    output logic [7:0]                sr_d,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [$clog2(N/8):0]      byte_count,
    output logic                      timeout_err,
    output logic [CW-1:0]             words_done
);

    localparam int NB = N / 8;
    localparam int BW = $clog2(NB) + 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] NB_C   = BW'(NB);
    localparam logic [BW-1:0] LAST_C = BW'(NB - 1);
    localparam logic [IW-1:0] IDLE_LAST =
        (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   idle, idle_n;
    logic            terr, terr_n;
    logic [CW-1:0]   done, done_n;

    // State and counters; rst returns everything to an empty COLLECT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            cnt   <= '0;
            idle  <= '0;
            terr  <= 1'b0;
            done  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idle  <= idle_n;
            terr  <= terr_n;
            done  <= done_n;
        end
    end

    // Next-state, handshake and shift-enable decode.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idle_n     = idle;
        terr_n     = 1'b0;
        done_n     = done;
        in_ready   = 1'b0;
        sr_h       = 1'b0;
        sr_d       = in_data;
        word_valid = 1'b0;
        unique case (state)
            COLLECT: begin
                in_ready = 1'b1;
                sr_h     = in_valid;
                if (in_valid) begin
                    // An accept always beats a pending timeout.
                    idle_n = '0;
                    if (cnt == LAST_C) begin
                        cnt_n   = NB_C;
                        state_n = HOLD;
                    end else begin
                        cnt_n = cnt + BW'(1);
                    end
                end else if (TIMEOUT > 0 && cnt != '0) begin
                    if (idle == IDLE_LAST) begin
                        cnt_n  = '0;
                        idle_n = '0;
                        terr_n = 1'b1;
                    end else if (idle != IDLE_MAX) begin
                        idle_n = idle + IW'(1);
                    end
                end else begin
                    idle_n = '0;
                end
            end
            HOLD: begin
                word_valid = 1'b1;
                idle_n     = '0;
                if (word_ready) begin
                    state_n = COLLECT;
                    cnt_n   = '0;
                    done_n  = done + CW'(1);
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

    assign byte_count  = cnt;
    assign timeout_err = terr;
    assign words_done  = done;

endmodule
